// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared field positions, opcodes, functs and ALU codes for the decode stage
package decode_stage_pkg;

  localparam int OP_LSB    = 26;
  localparam int OP_W      = 6;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int SHAMT_W   = 5;
  localparam int FUNCT_LSB = 0;
  localparam int FUNCT_W   = 6;
  localparam int IMM_LSB   = 0;
  localparam int IMM_W     = 16;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_code_e;

  typedef struct packed {
    logic alu_src;
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic branch_ne;
  } ctrl_t;

endpackage

// File: rtl/decode_stage_insn_decode_comb.sv
// rtl/decode_stage_insn_decode_comb.sv - pure combinational instruction decode (fields, control, ALU code, immediate)
module decode_stage_insn_decode_comb
  import decode_stage_pkg::*;
#(
  parameter int INSN_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int REG_NUM_WIDTH = 5
) (
  input  logic [INSN_WIDTH-1:0]    insn,
  output logic [OP_W-1:0]          op,
  output logic [REG_NUM_WIDTH-1:0] rs,
  output logic [REG_NUM_WIDTH-1:0] rt,
  output logic [REG_NUM_WIDTH-1:0] dst,
  output logic [SHAMT_W-1:0]       shamt,
  output logic [DATA_WIDTH-1:0]    imm,
  output alu_code_e                alu_code,
  output ctrl_t                    ctrl,
  output logic                     illegal,
  output logic                     uses_rt
);

  logic [FUNCT_W-1:0]       funct;
  logic [IMM_W-1:0]         imm16;
  logic [REG_NUM_WIDTH-1:0] rd;
  logic                     reg_dst;
  logic                     zero_ext;

  assign op    = insn[OP_LSB +: OP_W];
  assign rs    = insn[RS_LSB +: REG_NUM_WIDTH];
  assign rt    = insn[RT_LSB +: REG_NUM_WIDTH];
  assign rd    = insn[RD_LSB +: REG_NUM_WIDTH];
  assign shamt = insn[SHAMT_LSB +: SHAMT_W];
  assign funct = insn[FUNCT_LSB +: FUNCT_W];
  assign imm16 = insn[IMM_LSB +: IMM_W];

  assign dst = reg_dst ? rd : rt;
  assign imm = zero_ext ? {{(DATA_WIDTH-IMM_W){1'b0}}, imm16}
                        : {{(DATA_WIDTH-IMM_W){imm16[IMM_W-1]}}, imm16};

  always_comb begin
    ctrl     = '0;
    alu_code = ALU_ADD;
    illegal  = 1'b0;
    reg_dst  = 1'b0;
    zero_ext = 1'b0;
    uses_rt  = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        uses_rt        = 1'b1;
        reg_dst        = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          FN_ADD:  alu_code = ALU_ADD;
          FN_SUB:  alu_code = ALU_SUB;
          FN_AND:  alu_code = ALU_AND;
          FN_OR:   alu_code = ALU_OR;
          FN_SLT:  alu_code = ALU_SLT;
          default: begin
            illegal        = 1'b1;
            reg_dst        = 1'b0;
            ctrl.reg_write = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
      end
      OP_SW: begin
        uses_rt        = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        uses_rt     = 1'b1;
        ctrl.branch = 1'b1;
        alu_code    = ALU_SUB;
      end
      OP_BNE: begin
        uses_rt        = 1'b1;
        ctrl.branch_ne = 1'b1;
        alu_code       = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_ANDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        alu_code       = ALU_AND;
        zero_ext       = 1'b1;
      end
      OP_ORI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        alu_code       = ALU_OR;
        zero_ext       = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered ID stage: decode, load-use interlock, branch flush, stall handshake
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int INSN_WIDTH    = 32,
  parameter int PC_WIDTH      = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int REG_NUM_WIDTH = 5,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid,
  input  logic [INSN_WIDTH-1:0]    if_insn,
  input  logic [PC_WIDTH-1:0]      if_pc,
  output logic                     id_ready,
  input  logic                     ex_ready,
  input  logic                     ex_flush,
  output logic                     out_valid,
  output logic [PC_WIDTH-1:0]      out_pc,
  output logic [5:0]               out_op,
  output logic [REG_NUM_WIDTH-1:0] out_rs,
  output logic [REG_NUM_WIDTH-1:0] out_rt,
  output logic [REG_NUM_WIDTH-1:0] out_dst,
  output logic [4:0]               out_shamt,
  output logic [DATA_WIDTH-1:0]    out_imm,
  output alu_code_e                out_alu_code,
  output logic                     out_alu_src,
  output logic                     out_mem_to_reg,
  output logic                     out_reg_write,
  output logic                     out_mem_read,
  output logic                     out_mem_write,
  output logic                     out_branch,
  output logic                     out_branch_ne,
  output logic                     out_illegal,
  output logic [CNT_WIDTH-1:0]     stall_count
);

  logic [OP_W-1:0]          dec_op;
  logic [REG_NUM_WIDTH-1:0] dec_rs, dec_rt, dec_dst;
  logic [SHAMT_W-1:0]       dec_shamt;
  logic [DATA_WIDTH-1:0]    dec_imm;
  alu_code_e                dec_alu_code;
  ctrl_t                    dec_ctrl;
  logic                     dec_illegal, dec_uses_rt;

  decode_stage_insn_decode_comb #(
    .INSN_WIDTH   (INSN_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .REG_NUM_WIDTH(REG_NUM_WIDTH)
  ) u_insn_decode_comb (
    .insn    (if_insn),
    .op      (dec_op),
    .rs      (dec_rs),
    .rt      (dec_rt),
    .dst     (dec_dst),
    .shamt   (dec_shamt),
    .imm     (dec_imm),
    .alu_code(dec_alu_code),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .uses_rt (dec_uses_rt)
  );

  logic                     valid_q, valid_d;
  logic [PC_WIDTH-1:0]      pc_q, pc_d;
  logic [OP_W-1:0]          op_q, op_d;
  logic [REG_NUM_WIDTH-1:0] rs_q, rs_d, rt_q, rt_d, dst_q, dst_d;
  logic [SHAMT_W-1:0]       shamt_q, shamt_d;
  logic [DATA_WIDTH-1:0]    imm_q, imm_d;
  alu_code_e                alu_code_q, alu_code_d;
  ctrl_t                    ctrl_q, ctrl_d;
  logic                     illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0]     stall_count_q, stall_count_d;
  logic                     hazard;

  // A load still in ID/EX whose result the incoming instruction reads.
  assign hazard = valid_q & ctrl_q.mem_read & (dst_q != '0) & if_valid &
                  ((dec_rs == dst_q) | (dec_uses_rt & (dec_rt == dst_q)));

  assign id_ready = ex_ready & ~hazard & ~ex_flush;

  always_comb begin
    valid_d       = valid_q;
    pc_d          = pc_q;
    op_d          = op_q;
    rs_d          = rs_q;
    rt_d          = rt_q;
    dst_d         = dst_q;
    shamt_d       = shamt_q;
    imm_d         = imm_q;
    alu_code_d    = alu_code_q;
    ctrl_d        = ctrl_q;
    illegal_d     = illegal_q;
    stall_count_d = stall_count_q;
    if (ex_flush) begin
      valid_d   = 1'b0;
      ctrl_d    = '0;
      illegal_d = 1'b0;
    end else if (!ex_ready) begin
      valid_d = valid_q;
    end else if (hazard) begin
      valid_d   = 1'b0;
      ctrl_d    = '0;
      illegal_d = 1'b0;
      if (stall_count_q != {CNT_WIDTH{1'b1}}) begin
        stall_count_d = stall_count_q + CNT_WIDTH'(1);
      end
    end else begin
      valid_d    = if_valid;
      pc_d       = if_pc;
      op_d       = dec_op;
      rs_d       = dec_rs;
      rt_d       = dec_rt;
      dst_d      = dec_dst;
      shamt_d    = dec_shamt;
      imm_d      = dec_imm;
      alu_code_d = dec_alu_code;
      // Empty slots must never carry live control into EX.
      ctrl_d     = if_valid ? dec_ctrl : '0;
      illegal_d  = if_valid & dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q       <= 1'b0;
      pc_q          <= '0;
      op_q          <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      dst_q         <= '0;
      shamt_q       <= '0;
      imm_q         <= '0;
      alu_code_q    <= ALU_ADD;
      ctrl_q        <= '0;
      illegal_q     <= 1'b0;
      stall_count_q <= '0;
    end else begin
      valid_q       <= valid_d;
      pc_q          <= pc_d;
      op_q          <= op_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      dst_q         <= dst_d;
      shamt_q       <= shamt_d;
      imm_q         <= imm_d;
      alu_code_q    <= alu_code_d;
      ctrl_q        <= ctrl_d;
      illegal_q     <= illegal_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_pc         = pc_q;
  assign out_op         = op_q;
  assign out_rs         = rs_q;
  assign out_rt         = rt_q;
  assign out_dst        = dst_q;
  assign out_shamt      = shamt_q;
  assign out_imm        = imm_q;
  assign out_alu_code   = alu_code_q;
  assign out_alu_src    = ctrl_q.alu_src;
  assign out_mem_to_reg = ctrl_q.mem_to_reg;
  assign out_reg_write  = ctrl_q.reg_write;
  assign out_mem_read   = ctrl_q.mem_read;
  assign out_mem_write  = ctrl_q.mem_write;
  assign out_branch     = ctrl_q.branch;
  assign out_branch_ne  = ctrl_q.branch_ne;
  assign out_illegal    = illegal_q;
  assign stall_count    = stall_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int CW = 3;
  localparam int K_LOAD = 0, K_BUB = 1, K_HOLD = 2, K_FLUSH = 3;

  localparam logic [31:0] ADD9   = 32'h01084820;
  localparam logic [31:0] ADD900 = 32'h00004820;
  localparam logic [31:0] LW8    = 32'h8C080000;
  localparam logic [31:0] LW0    = 32'h8C000000;
  localparam logic [31:0] LW2    = 32'h8C020000;
  localparam logic [31:0] SW8    = 32'hAC080004;
  localparam logic [31:0] ANDI   = 32'h3022FFFF;
  localparam logic [31:0] ADDI   = 32'h2022FFFF;
  localparam logic [31:0] ORI    = 32'h34438000;
  localparam logic [31:0] BNE    = 32'h15090004;
  localparam logic [31:0] ILLOP  = 32'hFC000000;
  localparam logic [31:0] ILLFN  = 32'h0000003F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, if_valid, id_ready, ex_ready, ex_flush, out_valid;
  logic [31:0] if_insn, if_pc, out_pc, out_imm;
  logic [5:0] out_op;
  logic [4:0] out_rs, out_rt, out_dst, out_shamt;
  alu_code_e out_alu_code;
  logic out_alu_src, out_mem_to_reg, out_reg_write, out_mem_read, out_mem_write;
  logic out_branch, out_branch_ne, out_illegal;
  logic [CW-1:0] stall_count;

  decode_stage #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_insn(if_insn), .if_pc(if_pc),
    .id_ready(id_ready), .ex_ready(ex_ready), .ex_flush(ex_flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_op(out_op), .out_rs(out_rs),
    .out_rt(out_rt), .out_dst(out_dst), .out_shamt(out_shamt), .out_imm(out_imm),
    .out_alu_code(out_alu_code), .out_alu_src(out_alu_src),
    .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_branch(out_branch), .out_branch_ne(out_branch_ne),
    .out_illegal(out_illegal), .stall_count(stall_count)
  );

  typedef struct {
    logic          v;
    logic [31:0]   pc;
    logic [4:0]    dst;
    logic [2:0]    alu;
    logic [31:0]   imm;
    logic          asrc, m2r, rw, mr, mw, br, bne, ill;
    logic [CW-1:0] sc;
    logic          chk_dst;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t clear_ctrl(input exp_t e);
    exp_t r = e;
    r.v = 1'b0; r.asrc = 1'b0; r.m2r = 1'b0; r.rw = 1'b0; r.mr = 1'b0;
    r.mw = 1'b0; r.br = 1'b0; r.bne = 1'b0; r.ill = 1'b0;
    return r;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] insn, input logic [31:0] pc);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    op = insn[31:26];
    fn = insn[5:0];
    e = '{default: '0};
    e.v = 1'b1; e.pc = pc; e.dst = insn[20:16]; e.alu = ALU_ADD; e.chk_dst = 1'b1;
    e.imm = {{16{insn[15]}}, insn[15:0]};
    case (op)
      6'h00: begin
        e.dst = insn[15:11]; e.rw = 1'b1;
        case (fn)
          6'h20: e.alu = ALU_ADD;
          6'h22: e.alu = ALU_SUB;
          6'h24: e.alu = ALU_AND;
          6'h25: e.alu = ALU_OR;
          6'h2A: e.alu = ALU_SLT;
          default: begin e.ill = 1'b1; e.rw = 1'b0; e.chk_dst = 1'b0; end
        endcase
      end
      6'h23: begin e.asrc = 1'b1; e.m2r = 1'b1; e.rw = 1'b1; e.mr = 1'b1; end
      6'h2B: begin e.asrc = 1'b1; e.mw = 1'b1; end
      6'h04: begin e.br = 1'b1; e.alu = ALU_SUB; end
      6'h05: begin e.bne = 1'b1; e.alu = ALU_SUB; end
      6'h08: begin e.asrc = 1'b1; e.rw = 1'b1; end
      6'h0C: begin e.asrc = 1'b1; e.rw = 1'b1; e.alu = ALU_AND; e.imm = {16'h0, insn[15:0]}; end
      6'h0D: begin e.asrc = 1'b1; e.rw = 1'b1; e.alu = ALU_OR; e.imm = {16'h0, insn[15:0]}; end
      default: begin e.ill = 1'b1; e.chk_dst = 1'b0; end
    endcase
    return e;
  endfunction

  task automatic cmp_out(input exp_t e);
    chk("out_valid", 64'(out_valid), 64'(e.v));
    chk("alu_src", 64'(out_alu_src), 64'(e.asrc));
    chk("mem_to_reg", 64'(out_mem_to_reg), 64'(e.m2r));
    chk("reg_write", 64'(out_reg_write), 64'(e.rw));
    chk("mem_read", 64'(out_mem_read), 64'(e.mr));
    chk("mem_write", 64'(out_mem_write), 64'(e.mw));
    chk("branch", 64'(out_branch), 64'(e.br));
    chk("branch_ne", 64'(out_branch_ne), 64'(e.bne));
    chk("illegal", 64'(out_illegal), 64'(e.ill));
    chk("stall_count", 64'(stall_count), 64'(e.sc));
    if (e.v) begin
      chk("out_pc", 64'(out_pc), 64'(e.pc));
      chk("alu_code", 64'(out_alu_code), 64'(e.alu));
      chk("out_imm", 64'(out_imm), 64'(e.imm));
      if (e.chk_dst) chk("out_dst", 64'(out_dst), 64'(e.dst));
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                     input logic exr, input logic fl, input logic exp_idr, input int kind);
    exp_t n;
    @(negedge clk);
    if_valid = v; if_insn = insn; if_pc = pc; ex_ready = exr; ex_flush = fl;
    #1;
    chk("id_ready", 64'(id_ready), 64'(exp_idr));
    n = m;
    case (kind)
      K_LOAD: begin
        n = ref_decode(insn, pc);
        n.sc = m.sc;
        if (!v) n = clear_ctrl(n);
      end
      K_BUB: begin
        n = clear_ctrl(m);
        if (n.sc != {CW{1'b1}}) n.sc = n.sc + 1'b1;
      end
      K_FLUSH: n = clear_ctrl(m);
      default: n = m;
    endcase
    sb.push_back(n);
    m = n;
    @(posedge clk);
    #1;
    cmp_out(sb.pop_front());
  endtask

  initial begin
    rst = 1'b0; if_valid = 1'b0; if_insn = '0; if_pc = '0; ex_ready = 1'b0; ex_flush = 1'b0;
    m = '{default: '0};
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_stall", 64'(stall_count), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_imm", 64'(out_imm), 64'd0);
    chk("rst_reg_write", 64'(out_reg_write), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    cyc(1'b1, ADD9,   32'h100, 1'b1, 1'b0, 1'b1, K_LOAD);
    chk("add_dst9", 64'(out_dst), 64'd9);

    cyc(1'b1, LW8,    32'h104, 1'b1, 1'b0, 1'b1, K_LOAD);
    cyc(1'b1, ADD9,   32'h108, 1'b1, 1'b0, 1'b0, K_BUB);
    cyc(1'b1, ADD9,   32'h108, 1'b1, 1'b0, 1'b1, K_LOAD);
    chk("stall_after_lu", 64'(stall_count), 64'd1);

    cyc(1'b1, LW0,    32'h10C, 1'b1, 1'b0, 1'b1, K_LOAD);
    cyc(1'b1, ADD900, 32'h110, 1'b1, 1'b0, 1'b1, K_LOAD);

    cyc(1'b1, LW8,    32'h114, 1'b1, 1'b0, 1'b1, K_LOAD);
    cyc(1'b1, SW8,    32'h118, 1'b1, 1'b0, 1'b0, K_BUB);
    cyc(1'b1, SW8,    32'h118, 1'b1, 1'b0, 1'b1, K_LOAD);
    cyc(1'b1, LW2,    32'h11C, 1'b1, 1'b0, 1'b1, K_LOAD);
    cyc(1'b1, ADDI,   32'h120, 1'b1, 1'b0, 1'b1, K_LOAD);
    chk("addi_imm", 64'(out_imm), 64'hFFFFFFFF);

    cyc(1'b1, ANDI,   32'h124, 1'b1, 1'b0, 1'b1, K_LOAD);
    chk("andi_imm", 64'(out_imm), 64'h0000FFFF);
    cyc(1'b1, ORI,    32'h128, 1'b1, 1'b0, 1'b1, K_LOAD);
    cyc(1'b1, BNE,    32'h12C, 1'b1, 1'b0, 1'b1, K_LOAD);

    cyc(1'b1, ADD9,   32'h130, 1'b0, 1'b0, 1'b0, K_HOLD);
    cyc(1'b1, ADD9,   32'h130, 1'b0, 1'b1, 1'b0, K_FLUSH);
    cyc(1'b1, ADD9,   32'h130, 1'b0, 1'b0, 1'b0, K_HOLD);
    cyc(1'b1, ADD9,   32'h130, 1'b1, 1'b0, 1'b1, K_LOAD);

    cyc(1'b1, ILLOP,  32'h134, 1'b1, 1'b0, 1'b1, K_LOAD);
    cyc(1'b1, ILLFN,  32'h138, 1'b1, 1'b0, 1'b1, K_LOAD);
    cyc(1'b0, ADD9,   32'h13C, 1'b1, 1'b0, 1'b1, K_LOAD);

    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, LW8,  32'h200 + 32'(i * 8), 1'b1, 1'b0, 1'b1, K_LOAD);
      cyc(1'b1, ADD9, 32'h204 + 32'(i * 8), 1'b1, 1'b0, 1'b0, K_BUB);
      cyc(1'b1, ADD9, 32'h204 + 32'(i * 8), 1'b1, 1'b0, 1'b1, K_LOAD);
    end
    chk("stall_saturated", 64'(stall_count), 64'd7);

    cyc(1'b1, LW8,    32'h300, 1'b1, 1'b0, 1'b1, K_LOAD);
    cyc(1'b1, ADD9,   32'h304, 1'b0, 1'b0, 1'b0, K_HOLD);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_mem_read", 64'(out_mem_read), 64'd0);
    chk("midrst_stall", 64'(stall_count), 64'd0);
    chk("midrst_pc", 64'(out_pc), 64'd0);
    @(negedge clk);
    rst = 1'b1; if_valid = 1'b0; ex_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
